// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the serial-in / parallel-out register.
package sipo_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } sipo_state_e;

   localparam int SIPO_DEFAULT_WIDTH = 8;

   // Counter must reach WIDTH when a trailing parity bit is part of the frame.
   function automatic int sipo_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Frame bit counter: counts sampled bits 0..FRAME-1 and flags the last one.
module sipo_bit_counter #(
   parameter int FRAME = 8,
   parameter int CW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic          last
);

   assign last = en && (count == CW'(FRAME - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (en) begin
         count <= last ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/sipo_register.sv
// Serial-in / parallel-out register with a one-word output buffer.
// Define SIPO_PARITY_EN to append a trailing even-parity bit to every frame.
module sipo_register
   import sipo_pkg::*;
#(
   parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ser_valid,
   input  logic             serial_in,
   output logic [WIDTH-1:0] par_out,
   output logic             par_valid,
   input  logic             par_ready,
   output logic             busy,
   output logic             overrun,
   output logic             parity_err
);

   // par_out/par_valid form a valid/ready pair: a word transfers on any cycle
   // with par_valid && par_ready; par_out holds steady until that transfer.

   localparam int CW = sipo_cnt_width(WIDTH);
`ifdef SIPO_PARITY_EN
   localparam int FRAME = WIDTH + 1;
   localparam int SW    = WIDTH;
`else
   localparam int FRAME = WIDTH;
   localparam int SW    = WIDTH - 1;
`endif

   logic [CW-1:0]    bit_count;
   logic             frame_done;
   logic [SW-1:0]    shreg;
   logic             shift_en;
   logic [WIDTH-1:0] word_next;
   logic             perr_next;
   sipo_state_e      state;
   sipo_state_e      state_next;
   logic             load;
   logic             drop;

   sipo_bit_counter #(
      .FRAME (FRAME),
      .CW    (CW)
   ) u_counter (
      .clk   (clk),
      .rst   (rst),
      .en    (ser_valid),
      .count (bit_count),
      .last  (frame_done)
   );

   assign busy = (bit_count != '0);

   // The final data bit is taken straight from serial_in, so shreg only
   // needs to hold the bits that precede it in the frame.
`ifdef SIPO_PARITY_EN
   assign shift_en  = ser_valid && !frame_done;
   assign word_next = shreg;
   assign perr_next = ^{shreg, serial_in};
`else
   assign shift_en  = ser_valid;
   assign word_next = {shreg, serial_in};
   assign perr_next = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg <= '0;
      end else if (shift_en) begin
         shreg <= SW'({shreg, serial_in});
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (frame_done) state_next = FULL;
         FULL:    if (par_ready && !frame_done) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   // A completed frame replaces the buffered word only if the buffer is
   // empty or being drained this same cycle; otherwise it is dropped.
   always_comb begin
      par_valid = (state == FULL);
      load      = frame_done && ((state == EMPTY) || par_ready);
      drop      = frame_done && (state == FULL) && !par_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         par_out    <= '0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= drop;
         if (load) begin
            par_out    <= word_next;
            parity_err <= perr_next;
         end
      end
   end

endmodule

// File: tb/tb_sipo_register.sv
// Self-checking bench for sipo_register: directed scenarios then random traffic
// against a queue-based reference model. Honours SIPO_PARITY_EN.
module tb_sipo_register;

   localparam int WIDTH = 8;
`ifdef SIPO_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             ser_valid;
   logic             serial_in;
   logic             par_ready;
   logic [WIDTH-1:0] par_out;
   logic             par_valid;
   logic             busy;
   logic             overrun;
   logic             parity_err;

   int checks = 0;
   int errors = 0;

   logic             m_bits[$];
   logic [WIDTH-1:0] m_word  = '0;
   logic             m_valid = 1'b0;
   logic             m_ovr   = 1'b0;
   logic             m_perr  = 1'b0;

   sipo_register #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .ser_valid  (ser_valid),
      .serial_in  (serial_in),
      .par_out    (par_out),
      .par_valid  (par_valid),
      .par_ready  (par_ready),
      .busy       (busy),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: collect sampled bits of the current frame in a queue and
   // build the word arithmetically once the frame length is reached.
   task automatic model_edge(input logic r, input logic sv, input logic si, input logic pr);
      logic             done;
      logic [WIDTH-1:0] w;
      logic             p;
      if (r) begin
         m_bits.delete();
         m_valid = 1'b0;
         m_word  = '0;
         m_perr  = 1'b0;
         m_ovr   = 1'b0;
      end else begin
         done = 1'b0;
         w    = '0;
         p    = 1'b0;
         if (sv) begin
            m_bits.push_back(si);
            if (m_bits.size() == FRAME) begin
               done = 1'b1;
               for (int i = 0; i < WIDTH; i++) w = (w << 1) | WIDTH'(m_bits[i]);
`ifdef SIPO_PARITY_EN
               for (int i = 0; i < FRAME; i++) p = p ^ m_bits[i];
`endif
               m_bits.delete();
            end
         end
         m_ovr = done && m_valid && !pr;
         if (done && (!m_valid || pr)) begin
            m_word  = w;
            m_perr  = p;
            m_valid = 1'b1;
         end else if (m_valid && pr) begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic cyc(input logic r, input logic sv, input logic si, input logic pr);
      @(negedge clk);
      rst       = r;
      ser_valid = sv;
      serial_in = si;
      par_ready = pr;
      @(posedge clk);
      model_edge(r, sv, si, pr);
      #1;
      chk("par_out",    32'(par_out),    32'(m_word));
      chk("par_valid",  32'(par_valid),  32'(m_valid));
      chk("busy",       32'(busy),       32'(m_bits.size() != 0));
      chk("overrun",    32'(overrun),    32'(m_ovr));
      chk("parity_err", 32'(parity_err), 32'(m_perr));
   endtask

   function automatic logic [WIDTH:0] frame_of(input logic [WIDTH-1:0] w);
`ifdef SIPO_PARITY_EN
      return {w, ^w};
`else
      return {1'b0, w};
`endif
   endfunction

   // Sends bits f[n-1]..f[0]; gap idle cycles follow every bit but the last.
   task automatic send_frame(input logic [WIDTH:0] f, input int n, input int gap,
                             input logic pr, input logic last_pr);
      for (int i = n - 1; i >= 0; i--) begin
         cyc(1'b0, 1'b1, f[i], (i == 0) ? last_pr : pr);
         if (i != 0) begin
            for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, pr);
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      ser_valid = 1'b0;
      serial_in = 1'b0;
      par_ready = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      chk("reset_par_valid", 32'(par_valid), 32'd0);
      chk("reset_par_out",   32'(par_out),   32'd0);

      // Continuous frame, consumer always ready.
      send_frame(frame_of(8'hB2), FRAME, 0, 1'b1, 1'b1);
      chk("cont_word",  32'(par_out),   32'hB2);
      chk("cont_valid", 32'(par_valid), 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("cont_consumed", 32'(par_valid), 32'd0);

      // ser_valid toggling every cycle.
      send_frame(frame_of(8'hB2), FRAME, 1, 1'b1, 1'b1);
      chk("gap_word", 32'(par_out), 32'hB2);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);

      // Overrun: second frame dropped while the first is unconsumed.
      send_frame(frame_of(8'hB2), FRAME, 0, 1'b0, 1'b0);
      send_frame(frame_of(8'h5A), FRAME, 0, 1'b0, 1'b0);
      chk("ovr_pulse", 32'(overrun), 32'd1);
      chk("ovr_keep",  32'(par_out), 32'hB2);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("ovr_one_cycle", 32'(overrun), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("ovr_drained", 32'(par_valid), 32'd0);

      // Handshake coinciding with the second frame's last bit.
      send_frame(frame_of(8'hB2), FRAME, 0, 1'b0, 1'b0);
      send_frame(frame_of(8'h5A), FRAME, 0, 1'b0, 1'b1);
      chk("coinc_word",  32'(par_out),   32'h5A);
      chk("coinc_valid", 32'(par_valid), 32'd1);
      chk("coinc_ovr",   32'(overrun),   32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);

      // Reset mid-frame discards partial bits.
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      chk("midreset_busy", 32'(busy), 32'd0);
      send_frame(frame_of(8'h0F), FRAME, 0, 1'b1, 1'b1);
      chk("midreset_word", 32'(par_out), 32'h0F);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SIPO_PARITY_EN
      send_frame({8'hB2, 1'b0}, FRAME, 0, 1'b1, 1'b1);
      chk("par_good", 32'(parity_err), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      send_frame({8'hB2, 1'b1}, FRAME, 0, 1'b1, 1'b1);
      chk("par_bad",      32'(parity_err), 32'd1);
      chk("par_bad_word", 32'(par_out),    32'hB2);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
`endif

      // Random traffic with occasional resets and a mostly-stalled consumer.
      for (int n = 0; n < 2000; n++) begin
         cyc(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 2) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sipo_register.md
SIPO_REGISTER -- requirements
Module: sipo_register

Interface
REQ-001 Parameter: WIDTH, 8, parallel word width in bits (2..32).
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: ser_valid  input  1  serial_in carries a valid bit this cycle.
REQ-005 Port: serial_in  input  1  serial data bit, MSB of word first.
REQ-006 Port: par_out  output  WIDTH  assembled parallel word.
REQ-007 Port: par_valid  output  1  par_out holds an unconsumed word.
REQ-008 Port: par_ready  input  1  consumer accepts par_out when par_valid.
REQ-009 Port: busy  output  1  partial word in shift register (bit count nonzero).
REQ-010 Port: overrun  output  1  one-cycle pulse: completed word dropped.
REQ-011 Port: parity_err  output  1  parity status of the word on par_out.

Function
REQ-012 Sample serial_in only on cycles with ser_valid=1; otherwise hold shift register and bit count.
REQ-013 Shift left on each sampled bit: shreg <= {shreg[WIDTH-2:0], serial_in}. The first bit ends at par_out[WIDTH-1].
REQ-014 Bit counter 0..FRAME-1; FRAME=WIDTH (WIDTH+1 with parity). Wrap to 0 on the last sampled bit of a frame.
REQ-015 Frame completes on the last sampled bit. Next cycle: par_out=word, par_valid=1 (latency 1 clk after last bit).
REQ-016 FSM states: EMPTY (par_valid=0), FULL (par_valid=1).
  - EMPTY->FULL on frame complete.
  - FULL->EMPTY on par_valid&&par_ready with no frame completing that cycle.
  - FULL stays FULL if handshake and frame complete coincide; new word loaded, no overrun.
REQ-017 Frame complete in FULL without par_ready: drop the new word, keep par_out unchanged, overrun=1 for exactly one cycle.
REQ-018 Shift register continues accepting bits while FULL; reception is never stalled.
REQ-019 par_out stable whenever par_valid=1 and no handshake has occurred.
REQ-020 busy=1 iff bit counter != 0.
REQ-021 ser_valid gaps of any length mid-frame do not corrupt the frame.

Reset
REQ-022 On rst=1 at a clock edge: shreg=0, bit counter=0, FSM=EMPTY, par_out=0, par_valid=0, busy=0, overrun=0, parity_err=0.
REQ-023 Reset mid-frame discards partial bits. The first sampled bit after reset starts a new frame.
REQ-024 rst has priority over ser_valid and par_ready in the same cycle.

Configuration
REQ-025 Macro SIPO_PARITY_EN defined: each frame carries WIDTH data bits plus one trailing even-parity bit. parity_err=1 with the word when XOR(data,parity)=1. The word is still delivered.
REQ-026 Macro SIPO_PARITY_EN undefined: FRAME=WIDTH, no parity bit consumed, parity_err tied 0.

Structure
REQ-027 Package sipo_pkg holds:
  - FSM state enum (EMPTY, FULL);
  - default WIDTH constant;
  - counter-width function clog2(WIDTH+1).
REQ-028 Sub-module sipo_bit_counter (enable, wrap at FRAME-1, sync reset, last-bit flag) is the natural split. All other logic stays in sipo_register.

Verification
REQ-029 WIDTH=8, no parity, bits 1,0,1,1,0,0,1,0 continuous, par_ready=1 -> par_out=8'hB2, par_valid=1 for one cycle, 1 clk after 8th bit.
REQ-030 Same word with ser_valid toggling 1/0 each cycle -> par_out=8'hB2 after 16 cycles; busy=1 from first bit to last.
REQ-031 par_ready=0, send 8'hB2 then 8'h5A -> par_out stays 8'hB2, overrun pulses 1 cycle at end of 2nd frame; par_ready=1 then clears par_valid.
REQ-032 par_ready asserted in the same cycle the 2nd frame completes -> par_out=8'h5A, par_valid stays 1, overrun=0.
REQ-033 rst after 4 bits of 8'hFF, then send 8'h0F -> par_out=8'h0F, no stale bits.
REQ-034 SIPO_PARITY_EN: 8'hB2+parity 0 -> parity_err=0; 8'hB2+parity 1 -> parity_err=1, par_out=8'hB2.
